// File: rtl/axis_bram_playback.sv
// -----------------------------------------------------------------------------
// axis_bram_playback
//
// Replays a programmable range of BRAM words as an AXI4-Stream. The block
// drives the read side of a shared true-dual-port BRAM (read latency of one
// cycle) and streams words 0..last_l. It runs either one-shot or continuously
// wrapping. Downstream backpressure is absorbed by gating the BRAM enable. The
// BRAM holds its output register while en is low, so the read data itself acts
// as the one-beat output buffer.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   cfg_last               last word address of a pass (latched on start)
//   cfg_continuous         1 = wrap forever, 0 = single pass (latched on start)
//   cfg_start / cfg_stop   start request (IDLE only) / stop request (RUN only)
//   sts_busy               high whenever the engine is not idle
//   sts_addr               next address to be read
//   sts_passes             number of accepted tlast beats (wraps)
//   m_axis_*               AXI4-Stream master (tdata is the BRAM read data)
//   bram_porta_*           BRAM port driven by this block
// -----------------------------------------------------------------------------
module axis_bram_playback #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_last,
  input  logic                        cfg_continuous,
  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  output logic                        sts_busy,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_addr,
  output logic [31:0]                 sts_passes,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic                        bram_porta_en,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                     state_r, state_n;
  logic [BRAM_ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [BRAM_ADDR_WIDTH-1:0] last_r, last_n;
  logic                       continuous_r, continuous_n;
  logic                       tvalid_r, tvalid_n;
  logic                       tlast_r, tlast_n;
  logic [31:0]                passes_r, passes_n;

  logic                       advance_s;
  logic                       read_s;
  logic                       at_last_s;

  // The output slot can take a new word when it is empty or being drained.
  assign advance_s = ~tvalid_r | m_axis_tready;
  // A read is issued only while running, with room downstream and no stop.
  assign read_s    = (state_r == ST_RUN) & advance_s & ~cfg_stop;
  assign at_last_s = (addr_r == last_r);

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;
  assign bram_porta_en   = read_s;
  assign bram_porta_addr = addr_r;

  assign m_axis_tdata  = bram_porta_rddata;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;

  assign sts_busy   = (state_r != ST_IDLE);
  assign sts_addr   = addr_r;
  assign sts_passes = passes_r;

  // Next-state, address, stream-flag and pass-counter logic.
  always_comb begin
    state_n      = state_r;
    addr_n       = addr_r;
    last_n       = last_r;
    continuous_n = continuous_r;
    tvalid_n     = tvalid_r;
    tlast_n      = tlast_r;
    passes_n     = passes_r;

    if (tvalid_r & m_axis_tready & tlast_r) begin
      passes_n = passes_r + 32'd1;
    end else begin
      passes_n = passes_r;
    end

    // A read issued now shows up on rddata after the edge; otherwise the
    // beat is retired on acceptance or held while stalled.
    if (read_s) begin
      tvalid_n = 1'b1;
      tlast_n  = at_last_s;
    end else if (m_axis_tready) begin
      tvalid_n = 1'b0;
      tlast_n  = 1'b0;
    end else begin
      tvalid_n = tvalid_r;
      tlast_n  = tlast_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (cfg_start & ~cfg_stop) begin
          state_n      = ST_RUN;
          last_n       = cfg_last;
          continuous_n = cfg_continuous;
          addr_n       = {BRAM_ADDR_WIDTH{1'b0}};
          passes_n     = 32'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_stop) begin
          state_n = ST_FLUSH;
        end else if (read_s) begin
          if (at_last_s) begin
            if (continuous_r) begin
              addr_n = {BRAM_ADDR_WIDTH{1'b0}};
            end else begin
              // One-shot: keep the last address and drain the final beat.
              state_n = ST_FLUSH;
            end
          end else begin
            addr_n = addr_r + {{(BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Leave once the pending beat is accepted, or at once if none pends.
        if (advance_s) begin
          state_n = ST_IDLE;
          addr_n  = {BRAM_ADDR_WIDTH{1'b0}};
        end else begin
          state_n = ST_FLUSH;
        end
      end
      default: begin
        state_n = ST_IDLE;
        addr_n  = {BRAM_ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      addr_r       <= {BRAM_ADDR_WIDTH{1'b0}};
      last_r       <= {BRAM_ADDR_WIDTH{1'b0}};
      continuous_r <= 1'b0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      passes_r     <= 32'd0;
    end else begin
      state_r      <= state_n;
      addr_r       <= addr_n;
      last_r       <= last_n;
      continuous_r <= continuous_n;
      tvalid_r     <= tvalid_n;
      tlast_r      <= tlast_n;
      passes_r     <= passes_n;
    end
  end

endmodule

// File: tb/tb_axis_bram_playback.sv
// -----------------------------------------------------------------------------
// Testbench for axis_bram_playback. Contains a BRAM model with one-cycle read
// latency and holds data while en is low. Expected beats are queued by the
// stimulus from the memory contents and the configured range. A forked
// monitor pops and compares each accepted beat and checks that stalled beats
// stay stable.
// -----------------------------------------------------------------------------
module tb_axis_bram_playback;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] cfg_last;
  logic          cfg_continuous;
  logic          cfg_start;
  logic          cfg_stop;
  logic          sts_busy;
  logic [AW-1:0] sts_addr;
  logic [31:0]   sts_passes;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          bram_porta_clk;
  logic          bram_porta_rst;
  logic          bram_porta_en;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_rddata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 aclk = ~aclk;

  axis_bram_playback #(
    .AXIS_TDATA_WIDTH (DW),
    .BRAM_DATA_WIDTH  (DW),
    .BRAM_ADDR_WIDTH  (AW)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cfg_last          (cfg_last),
    .cfg_continuous    (cfg_continuous),
    .cfg_start         (cfg_start),
    .cfg_stop          (cfg_stop),
    .sts_busy          (sts_busy),
    .sts_addr          (sts_addr),
    .sts_passes        (sts_passes),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_en     (bram_porta_en),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_rddata (bram_porta_rddata)
  );

  // BRAM model: one-cycle read latency, output held while en is low.
  always @(posedge aclk) begin
    if (bram_porta_en) bram_porta_rddata <= mem[bram_porta_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Queue one full pass 0..last of the current memory contents.
  task automatic push_pass(input int last);
    beat_t b;
    for (int i = 0; i <= last; i++) begin
      b.data = mem[i];
      b.last = (i == last);
      exp_q.push_back(b);
    end
  endtask

  // Pulse cfg_start for one edge, then scramble the cfg inputs (must be ignored).
  task automatic start_run(input int last, input logic cont);
    cfg_last       = AW'(last);
    cfg_continuous = cont;
    cfg_start      = 1'b1;
    tick();
    cfg_start      = 1'b0;
    cfg_last       = AW'($urandom_range(0, 1023));
    cfg_continuous = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int c = 0; c < max_cycles && sts_busy; c++) tick();
    chk("idle_timeout", 32'(sts_busy), 32'd0);
  endtask

  // Monitor: compares accepted beats against the queue, checks stall stability.
  task automatic monitor_loop();
    bit            stalled = 1'b0;
    logic [DW-1:0] hd = '0;
    logic          hl = 1'b0;
    logic [AW-1:0] ha = '0;
    beat_t         b;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
          chk("stall_data", m_axis_tdata, hd);
          chk("stall_last", 32'(m_axis_tlast), 32'(hl));
          chk("stall_addr", 32'(bram_porta_addr), 32'(ha));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual data 0x%0h required no beat at %0t", m_axis_tdata, $time);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", m_axis_tdata, b.data);
            chk("beat_last", 32'(m_axis_tlast), 32'(b.last));
          end
        end
        if (m_axis_tvalid && !m_axis_tready) begin
          chk("stall_en", 32'(bram_porta_en), 32'd0);
          stalled = 1'b1;
          hd = m_axis_tdata;
          hl = m_axis_tlast;
          ha = bram_porta_addr;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn        = 1'b0;
    cfg_last       = '0;
    cfg_continuous = 1'b0;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    m_axis_tready  = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) + 32'h100;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_en", 32'(bram_porta_en), 32'd0);
    chk("rst_addr", 32'(sts_addr), 32'd0);
    chk("rst_busy", 32'(sts_busy), 32'd0);
    chk("rst_passes", sts_passes, 32'd0);
    chk("rst_bram_rst", 32'(bram_porta_rst), 32'd1);
    aresetn = 1'b1;
    tick();

    // One-shot, 8 words 0x100..0x107, tready always high
    push_pass(7);
    start_run(7, 1'b0);
    chk("t1_busy_k", 32'(sts_busy), 32'd1);
    chk("t1_en_k", 32'(bram_porta_en), 32'd1);
    chk("t1_addr_k", 32'(bram_porta_addr), 32'd0);
    tick();
    chk("t1_valid_k1", 32'(m_axis_tvalid), 32'd1);
    chk("t1_data_k1", m_axis_tdata, 32'h100);
    repeat (7) tick();
    chk("t1_busy_kN", 32'(sts_busy), 32'd1);
    chk("t1_tlast_kN", 32'(m_axis_tlast), 32'd1);
    tick();
    chk("t1_busy_kN1", 32'(sts_busy), 32'd0);
    chk("t1_passes", sts_passes, 32'd1);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // Continuous, cfg_last=3, three passes then stop with the last beat pending
    for (int i = 0; i < 4; i++) mem[i] = $urandom();
    repeat (3) push_pass(3);
    start_run(3, 1'b1);
    repeat (12) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("t2_passes", sts_passes, 32'd3);
    tick();
    chk("t2_busy", 32'(sts_busy), 32'd0);
    chk("t2_addr", 32'(sts_addr), 32'd0);
    chk("t2_queue", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    // Random backpressure, one-shot, 16 random words
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    push_pass(15);
    start_run(15, 1'b0);
    for (int c = 0; c < 400 && sts_busy; c++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t3_idle", 32'(sts_busy), 32'd0);
    m_axis_tready = 1'b1;
    chk("t3_passes", sts_passes, 32'd1);
    chk("t3_queue", 32'(exp_q.size()), 32'd0);

    // cfg_last=0 continuous, 5 beats accepted
    mem[0] = $urandom();
    repeat (5) push_pass(0);
    start_run(0, 1'b1);
    repeat (5) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    tick();
    chk("t4_busy", 32'(sts_busy), 32'd0);
    chk("t4_passes", sts_passes, 32'd5);
    chk("t4_queue", 32'(exp_q.size()), 32'd0);

    // Start mid-run with a different length is ignored
    for (int i = 0; i < 10; i++) mem[i] = $urandom();
    push_pass(5);
    start_run(5, 1'b0);
    repeat (2) tick();
    cfg_last       = AW'(9);
    cfg_continuous = 1'b1;
    cfg_start      = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_idle(50);
    chk("t5_passes", sts_passes, 32'd1);
    chk("t5_queue", 32'(exp_q.size()), 32'd0);

    // Start together with stop in IDLE stays idle
    cfg_last  = AW'(3);
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    chk("t5_ss_busy", 32'(sts_busy), 32'd0);
    chk("t5_ss_en", 32'(bram_porta_en), 32'd0);
    repeat (3) tick();
    chk("t5_ss_busy2", 32'(sts_busy), 32'd0);

    // Reset mid-stream at address 5; beats 0..3 are accepted before it
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.data = mem[i];
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    start_run(15, 1'b0);
    repeat (5) tick();
    chk("t6_addr5", 32'(sts_addr), 32'd5);
    aresetn = 1'b0;
    tick();
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_tlast", 32'(m_axis_tlast), 32'd0);
    chk("t6_en", 32'(bram_porta_en), 32'd0);
    chk("t6_busy", 32'(sts_busy), 32'd0);
    chk("t6_passes", sts_passes, 32'd0);
    chk("t6_addr", 32'(sts_addr), 32'd0);
    chk("t6_queue", 32'(exp_q.size()), 32'd0);
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) mem[i] = $urandom();
    push_pass(2);
    start_run(2, 1'b0);
    chk("t6_restart_addr", 32'(bram_porta_addr), 32'd0);
    chk("t6_restart_en", 32'(bram_porta_en), 32'd1);
    wait_idle(50);
    chk("t6_restart_passes", sts_passes, 32'd1);

    repeat (5) tick();
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
